// File: rtl/rgb_pwm_ctrl_pkg.sv
// Shared constants for the RGB PWM controller: register map, CTRL bit
// positions and the breathe FSM state encoding.
package rgb_pwm_ctrl_pkg;

  localparam logic [2:0] ADDR_DUTY_R   = 3'd0;
  localparam logic [2:0] ADDR_DUTY_G   = 3'd1;
  localparam logic [2:0] ADDR_DUTY_B   = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_LEVEL    = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_BREATHE = 1;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } breathe_state_t;

endpackage

// File: rtl/rgb_pwm_ctrl_chan.sv
// One PWM channel: shadow/active duty pair, breathe clamp, compare and
// registered output.
module rgb_pwm_chan
  import rgb_pwm_ctrl_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       load,
  input  logic       en,
  input  logic       breathe,
  input  logic [7:0] level,
  input  logic [7:0] ctr,
  output logic [7:0] shadow,
  output logic       pwm
);

  logic [7:0] active;
  logic [7:0] eff;
  logic       raw;

  // Active duty only changes at a period boundary, or freely while idle,
  // so a write can never shorten or stretch the pulse already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= 8'h00;
      active <= 8'h00;
      pwm    <= INVERT;
    end else begin
      if (wr) shadow <= din;
      if (!en || load) active <= shadow;
      pwm <= raw ^ INVERT;
    end
  end

  always_comb begin
    eff = active;
    if (breathe && (level < active)) eff = level;
    raw = en && (ctr < eff);
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Bus-attached RGB PWM controller: register file, prescaler, PWM counter
// and breathe triangle generator feeding three channel slices.
module rgb_pwm_ctrl
  import rgb_pwm_ctrl_pkg::*;
#(
  parameter bit         INVERT    = 1'b0,
  parameter logic [7:0] PRESC_RST = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b
);

  logic           en;
  logic           breathe;
  logic [7:0]     presc;
  logic [7:0]     pcnt;
  logic [7:0]     ctr;
  logic [7:0]     level;
  breathe_state_t state;

  logic       wr_en;
  logic       rd_en;
  logic       presc_wr;
  logic       tick;
  logic       wrap;
  logic [7:0] shadow_r;
  logic [7:0] shadow_g;
  logic [7:0] shadow_b;
  logic [7:0] rd_data;

  assign wr_en    = cs & we;
  assign rd_en    = cs & ~we;
  assign presc_wr = wr_en && (addr == ADDR_PRESCALE);
  assign tick     = en && (pcnt == presc);
  assign wrap     = tick && (ctr == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      breathe <= 1'b0;
      presc   <= PRESC_RST;
      dout    <= 8'h00;
    end else begin
      if (wr_en && (addr == ADDR_CTRL)) begin
        en      <= din[CTRL_EN];
        breathe <= din[CTRL_BREATHE];
      end
      if (presc_wr) presc <= din;
      if (rd_en) dout <= rd_data;
    end
  end

  // Timebase and breathe FSM; everything parks at zero/UP while disabled so
  // enabling always begins a clean period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= 8'h00;
      ctr   <= 8'h00;
      level <= 8'h00;
      state <= ST_UP;
    end else if (!en) begin
      pcnt  <= 8'h00;
      ctr   <= 8'h00;
      level <= 8'h00;
      state <= ST_UP;
    end else begin
      if (presc_wr || tick) pcnt <= 8'h00;
      else                  pcnt <= pcnt + 8'd1;
      if (tick) ctr <= ctr + 8'd1;
      if (wrap && breathe) begin
        case (state)
          ST_UP: begin
            level <= level + 8'd1;
            if (level == 8'hFE) state <= ST_DOWN;
          end
          ST_DOWN: begin
            level <= level - 8'd1;
            if (level == 8'h01) state <= ST_UP;
          end
          default: state <= ST_UP;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_DUTY_R:   rd_data = shadow_r;
      ADDR_DUTY_G:   rd_data = shadow_g;
      ADDR_DUTY_B:   rd_data = shadow_b;
      ADDR_CTRL:     rd_data = {6'd0, breathe, en};
      ADDR_PRESCALE: rd_data = presc;
      ADDR_LEVEL:    rd_data = level;
      ADDR_STATUS:   rd_data = {6'd0, en, state == ST_DOWN};
      default:       rd_data = 8'h00;
    endcase
  end

  rgb_pwm_chan #(.INVERT(INVERT)) u_chan_r (
    .clk(clk), .rst(rst), .wr(wr_en && (addr == ADDR_DUTY_R)), .din(din),
    .load(wrap), .en(en), .breathe(breathe), .level(level), .ctr(ctr),
    .shadow(shadow_r), .pwm(pwm_r)
  );

  rgb_pwm_chan #(.INVERT(INVERT)) u_chan_g (
    .clk(clk), .rst(rst), .wr(wr_en && (addr == ADDR_DUTY_G)), .din(din),
    .load(wrap), .en(en), .breathe(breathe), .level(level), .ctr(ctr),
    .shadow(shadow_g), .pwm(pwm_g)
  );

  rgb_pwm_chan #(.INVERT(INVERT)) u_chan_b (
    .clk(clk), .rst(rst), .wr(wr_en && (addr == ADDR_DUTY_B)), .din(din),
    .load(wrap), .en(en), .breathe(breathe), .level(level), .ctr(ctr),
    .shadow(shadow_b), .pwm(pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: two DUTs (plain and inverted) share one bus; a
// monitor scores register reads and per-period PWM high times from queues.
module tb_rgb_pwm_ctrl;
  import rgb_pwm_ctrl_pkg::*;

  localparam logic [7:0] PRESC_RST1 = 8'h05;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout0, dout1;
  logic       r0, g0, b0, r1, g1, b1;

  always #5 clk = ~clk;

  rgb_pwm_ctrl #(.INVERT(1'b0), .PRESC_RST(8'h00)) dut0 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout0), .pwm_r(r0), .pwm_g(g0), .pwm_b(b0)
  );

  rgb_pwm_ctrl #(.INVERT(1'b1), .PRESC_RST(PRESC_RST1)) dut1 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout1), .pwm_r(r1), .pwm_g(g1), .pwm_b(b1)
  );

  typedef struct {
    string      name;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } rd_item_t;

  // Expected high cycles per channel over a window, for the non-inverted DUT.
  typedef struct {
    string name;
    int    start;
    int    len;
    int    exp_r;
    int    exp_g;
    int    exp_b;
  } win_t;

  int       checks = 0;
  int       failures = 0;
  int       edge_cnt = 0;
  int       last_edge = 0;
  logic     rd_pending = 1'b0;
  rd_item_t rd_q[$];
  win_t     win_q[$];

  logic [7:0] sh_m [3];
  logic [1:0] ctrl_m;
  logic [7:0] presc_m;

  always @(posedge clk) begin
    edge_cnt   <= edge_cnt + 1;
    rd_pending <= cs & ~we;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] a,
                               input logic [7:0] d, input string name,
                               input logic [7:0] e0, input logic [7:0] e1);
    rd_item_t it;
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; din = d;
    if (!w) begin
      it.name = name; it.exp0 = e0; it.exp1 = e1;
      rd_q.push_back(it);
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    last_edge = edge_cnt;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    applyStimulus(1'b1, a, d, "", 8'h00, 8'h00);
  endtask

  task automatic bus_rd(input string name, input logic [2:0] a,
                        input logic [7:0] e0, input logic [7:0] e1);
    applyStimulus(1'b0, a, 8'h00, name, e0, e1);
  endtask

  task automatic wait_until(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic push_win(input string name, input int start, input int len,
                          input int er, input int eg, input int eb);
    win_t w;
    w.name = name; w.start = start; w.len = len;
    w.exp_r = er; w.exp_g = eg; w.exp_b = eb;
    win_q.push_back(w);
  endtask

  // Breathe level during PWM period p counted from enable (one triangle).
  function automatic int tri_level(input int p);
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] reg_exp(input logic [2:0] a);
    case (a)
      ADDR_DUTY_R:   return sh_m[0];
      ADDR_DUTY_G:   return sh_m[1];
      ADDR_DUTY_B:   return sh_m[2];
      ADDR_CTRL:     return {6'd0, ctrl_m};
      ADDR_PRESCALE: return presc_m;
      default:       return 8'h00;
    endcase
  endfunction

  initial begin : monitor
    rd_item_t it;
    win_t     cur;
    bit       busy;
    int       h0r, h0g, h0b, h1r, h1g, h1b;
    busy = 1'b0;
    h0r = 0; h0g = 0; h0b = 0; h1r = 0; h1g = 0; h1b = 0;
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        if (rd_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rd_scoreboard: read seen with no expectation queued");
        end else begin
          it = rd_q.pop_front();
          checkOutput({it.name, "_dut0"}, {24'd0, dout0}, {24'd0, it.exp0});
          checkOutput({it.name, "_dut1"}, {24'd0, dout1}, {24'd0, it.exp1});
        end
      end
      if (!busy && win_q.size() > 0 && win_q[0].start < edge_cnt) begin
        cur = win_q.pop_front();
        failures++;
        $display("[TB] FAIL late_%s: actual=%0d required=%0d", cur.name, edge_cnt, cur.start);
      end
      if (!busy && win_q.size() > 0 && win_q[0].start == edge_cnt) begin
        cur = win_q.pop_front();
        busy = 1'b1;
        h0r = 0; h0g = 0; h0b = 0; h1r = 0; h1g = 0; h1b = 0;
      end
      if (busy) begin
        h0r += int'(r0); h0g += int'(g0); h0b += int'(b0);
        h1r += int'(r1); h1g += int'(g1); h1b += int'(b1);
        if (edge_cnt == cur.start + cur.len - 1) begin
          checkOutput({cur.name, "_r_dut0"}, h0r, cur.exp_r);
          checkOutput({cur.name, "_g_dut0"}, h0g, cur.exp_g);
          checkOutput({cur.name, "_b_dut0"}, h0b, cur.exp_b);
          checkOutput({cur.name, "_r_dut1"}, h1r, cur.len - cur.exp_r);
          checkOutput({cur.name, "_g_dut1"}, h1g, cur.len - cur.exp_g);
          checkOutput({cur.name, "_b_dut1"}, h1b, cur.len - cur.exp_b);
          busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    logic [2:0] a;
    logic [7:0] d, g_old, g_new, b_old, b_new, dr, db, dg;
    int e, s, w, e2;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_pwm_dut0", {29'd0, r0, g0, b0}, 32'd0);
    checkOutput("rst_pwm_dut1", {29'd0, r1, g1, b1}, 32'd7);
    checkOutput("rst_dout_dut0", {24'd0, dout0}, 32'd0);
    rst = 1'b0;
    bus_rd("rst_presc", ADDR_PRESCALE, 8'h00, PRESC_RST1);
    bus_rd("rst_ctrl", ADDR_CTRL, 8'h00, 8'h00);
    bus_rd("rst_level", ADDR_LEVEL, 8'h00, 8'h00);
    bus_rd("rst_status", ADDR_STATUS, 8'h00, 8'h00);
    bus_rd("rst_addr7", 3'd7, 8'h00, 8'h00);

    // Randomised register traffic with EN held low.
    sh_m[0] = 8'h00; sh_m[1] = 8'h00; sh_m[2] = 8'h00; ctrl_m = 2'b00;
    presc_m = 8'($urandom_range(0, 255));
    bus_wr(ADDR_PRESCALE, presc_m);
    for (int i = 0; i < 20; i++) begin
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        if (a == ADDR_CTRL) d[0] = 1'b0;
        bus_wr(a, d);
        case (a)
          ADDR_DUTY_R:   sh_m[0] = d;
          ADDR_DUTY_G:   sh_m[1] = d;
          ADDR_DUTY_B:   sh_m[2] = d;
          ADDR_CTRL:     ctrl_m = d[1:0];
          ADDR_PRESCALE: presc_m = d;
          default: ;
        endcase
      end else begin
        bus_rd($sformatf("rand_rd_a%0d", a), a, reg_exp(a), reg_exp(a));
      end
    end
    bus_wr(ADDR_CTRL, 8'h00);

    // Static duty, PRESCALE = 0.
    bus_wr(ADDR_DUTY_R, 8'h40);
    bus_wr(ADDR_DUTY_G, 8'h00);
    bus_wr(ADDR_DUTY_B, 8'hFF);
    bus_wr(ADDR_PRESCALE, 8'h00);
    bus_wr(ADDR_CTRL, 8'h01);
    e = last_edge;
    push_win("static_p0", e + 1, 256, 64, 0, 255);
    push_win("static_p1", e + 257, 256, 64, 0, 255);
    wait_until(e + 1 + 512);
    bus_wr(ADDR_CTRL, 8'h00);

    // Asynchronous reset in the middle of a running period.
    bus_rd("pre_rst_duty_b", ADDR_DUTY_B, 8'hFF, 8'hFF);
    bus_wr(ADDR_CTRL, 8'h01);
    e = last_edge;
    wait_until(e + 10);
    checkOutput("pre_rst_pwm_r_dut0", {31'd0, r0}, 32'd1);
    checkOutput("pre_rst_pwm_r_dut1", {31'd0, r1}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_pwm_dut0", {29'd0, r0, g0, b0}, 32'd0);
    checkOutput("midrst_pwm_dut1", {29'd0, r1, g1, b1}, 32'd7);
    checkOutput("midrst_dout_dut0", {24'd0, dout0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd("midrst_presc", ADDR_PRESCALE, 8'h00, PRESC_RST1);
    bus_rd("midrst_ctrl", ADDR_CTRL, 8'h00, 8'h00);
    bus_rd("midrst_duty_r", ADDR_DUTY_R, 8'h00, 8'h00);

    // Mid-period duty write and a write landing exactly on the wrap tick.
    g_old = 8'($urandom_range(0, 255)); g_new = 8'($urandom_range(0, 255));
    b_old = 8'($urandom_range(0, 255)); b_new = 8'($urandom_range(0, 255));
    bus_wr(ADDR_PRESCALE, 8'h00);
    bus_wr(ADDR_DUTY_R, 8'h40);
    bus_wr(ADDR_DUTY_G, g_old);
    bus_wr(ADDR_DUTY_B, b_old);
    bus_wr(ADDR_CTRL, 8'h01);
    e = last_edge;
    push_win("glitch_p0", e + 1, 256, 64, g_old, b_old);
    push_win("glitch_p1", e + 257, 256, 192, g_new, b_old);
    push_win("wrapwr_p2", e + 513, 256, 192, g_new, b_old);
    push_win("wrapwr_p3", e + 769, 256, 192, g_new, b_new);
    wait_until(e + 128);
    bus_wr(ADDR_DUTY_R, 8'hC0);
    bus_wr(ADDR_DUTY_G, g_new);
    wait_until(e + 510);
    bus_wr(ADDR_DUTY_B, b_new);
    wait_until(e + 769 + 256);
    bus_wr(ADDR_CTRL, 8'h00);

    // Prescaler = 3, then a PRESCALE rewrite inside slot s of period 1.
    dr = 8'($urandom_range(0, 255));
    db = 8'($urandom_range(0, 255));
    s  = $urandom_range(1, 254);
    bus_wr(ADDR_PRESCALE, 8'h03);
    bus_wr(ADDR_DUTY_R, dr);
    bus_wr(ADDR_DUTY_G, 8'h80);
    bus_wr(ADDR_DUTY_B, db);
    bus_wr(ADDR_CTRL, 8'h01);
    e = last_edge;
    push_win("presc_p0", e + 1, 1024, 4 * dr, 512, 4 * db);
    push_win("presc_restart_p1", e + 1025, 1026,
             4 * dr + ((dr > s) ? 2 : 0), 512 + ((128 > s) ? 2 : 0),
             4 * db + ((db > s) ? 2 : 0));
    wait_until(e + 1024 + 4 * s);
    bus_wr(ADDR_PRESCALE, 8'h03);
    wait_until(e + 1025 + 1026);
    bus_wr(ADDR_CTRL, 8'h00);

    // Breathe mode up to and past the top of the triangle.
    dg = 8'($urandom_range(0, 255));
    bus_wr(ADDR_PRESCALE, 8'h00);
    bus_wr(ADDR_DUTY_R, 8'h20);
    bus_wr(ADDR_DUTY_G, dg);
    bus_wr(ADDR_DUTY_B, 8'hFF);
    bus_wr(ADDR_CTRL, 8'h03);
    e = last_edge;
    foreach (win_q[i]) ;
    for (int k = 0; k < 7; k++) begin
      int p;
      case (k)
        0: p = 0;   1: p = 1;   2: p = 2;   3: p = 40;
        4: p = 200; 5: p = 255; default: p = 256;
      endcase
      push_win($sformatf("breathe_p%0d", p), e + 1 + 256 * p, 256,
               min_i(32, tri_level(p)), min_i(dg, tri_level(p)),
               min_i(255, tri_level(p)));
    end
    wait_until(e + 256 + 8);
    bus_rd("breathe_level_p1", ADDR_LEVEL, 8'd1, 8'd1);
    wait_until(e + 256 * 255 + 8);
    bus_rd("breathe_level_top", ADDR_LEVEL, 8'd255, 8'd255);
    bus_rd("breathe_status_top", ADDR_STATUS, 8'h03, 8'h03);
    wait_until(e + 256 * 256 + 8);
    bus_rd("breathe_level_down", ADDR_LEVEL, 8'd254, 8'd254);
    bus_rd("breathe_status_down", ADDR_STATUS, 8'h03, 8'h03);

    // Clearing BREATHE freezes the level and the FSM direction.
    wait_until(e + 256 * 257 + 98);
    bus_wr(ADDR_CTRL, 8'h01);
    push_win("frozen_p258", e + 1 + 256 * 258, 256, 32, dg, 255);
    wait_until(e + 256 * 259 + 3);
    bus_rd("frozen_level", ADDR_LEVEL, 8'd253, 8'd253);
    bus_rd("frozen_status", ADDR_STATUS, 8'h03, 8'h03);

    // Disable mid-period, then re-enable.
    wait_until(e + 256 * 260 + 8'h50 - 2);
    bus_wr(ADDR_CTRL, 8'h00);
    w = last_edge;
    push_win("disabled", w + 1, 20, 0, 0, 0);
    bus_rd("disabled_level", ADDR_LEVEL, 8'h00, 8'h00);
    bus_rd("disabled_status", ADDR_STATUS, 8'h00, 8'h00);
    wait_until(w + 30);
    bus_wr(ADDR_CTRL, 8'h01);
    e2 = last_edge;
    push_win("reenable_p0", e2 + 1, 256, 32, dg, 255);
    wait_until(e2 + 1 + 256 + 2);

    checkOutput("win_q_drained", win_q.size(), 32'd0);
    checkOutput("rd_q_drained", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
- Bus-attached PWM controller that sits downstream of the 6502 core and upstream of the SB_RGBA_DRV RGB LED driver.
- Replaces static on/off GPIO bits with 8-bit per-channel brightness, a programmable PWM rate and a hardware "breathe" (triangle fade) mode.
- Driven from the core's peripheral select / write strobe; its three outputs connect directly to RGB0PWM/RGB1PWM/RGB2PWM.

Parameters:
- INVERT, 0: 1 inverts all three pwm outputs after the compare; reset level also inverts.
- PRESC_RST, 8'd0: reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock (12 MHz HFOSC domain)
- rst  input  1  asynchronous, active-high reset
- cs  input  1  register select, sampled on rising clk
- we  input  1  1 = write, 0 = read; qualified by cs
- addr  input  3  register index
- din  input  8  write data
- dout  output  8  read data, registered
- pwm_r  output  1  red channel PWM (to RGB1PWM)
- pwm_g  output  1  green channel PWM (to RGB2PWM)
- pwm_b  output  1  blue channel PWM (to RGB0PWM)

Behaviour:
- Reset is asynchronous, active-high and fixed as such. All registers clear to 0 except PRESCALE = PRESC_RST. dout = 0; pwm_* = INVERT.
- Register map:
  - 0 DUTY_R, 1 DUTY_G, 2 DUTY_B: R/W; reads return the shadow value.
  - 3 CTRL: bit0 EN, bit1 BREATHE; bits 7:2 read 0.
  - 4 PRESCALE: R/W.
  - 5 LEVEL: RO, current breathe level.
  - 6 STATUS: RO; bit0 = breathe direction (1 = down), bit1 = EN.
  - 7 reads 0; writes to 5–7 are ignored.
- Reads: cs & ~we at edge N → dout valid after edge N and held until the next read.
- Prescaler: 8-bit pcnt counts 0..PRESCALE. tick = (pcnt == PRESCALE); pcnt then wraps to 0. Any write to PRESCALE clears pcnt in the same edge.
- PWM counter: 8-bit ctr, increments on tick and wraps 255→0. Period = 256*(PRESCALE+1) clk.
- Duty update:
  - Writes land in a per-channel shadow register.
  - shadow→active copy happens on the tick where ctr wraps 255→0, so there are no glitches mid-period.
  - While EN = 0, the copy happens every cycle.
- Compare: raw_x = (ctr < eff_x).
  - eff_x = active_x when BREATHE = 0.
  - eff_x = min(active_x, level) when BREATHE = 1.
  - duty 0 → constantly off; duty 255 → on for 255 of 256 slots.
  - pwm_x = raw_x ^ INVERT, registered (1 clk after ctr).
- Breathe FSM, states UP/DOWN, advances once per PWM period (at the ctr wrap tick) when EN & BREATHE:
  - UP: level++. When level becomes 255 → DOWN.
  - DOWN: level--. When level becomes 0 → UP.
  - Full triangle = 510 periods.
- EN = 0:
  - pcnt, ctr and level are held at 0; state = UP.
  - pwm_x = INVERT.
  - Register writes still take effect.
- EN 0→1: counting starts from 0 on the next edge. The first period uses the current shadow values.
- Clearing BREATHE while EN = 1 freezes level (not reset); active duty then applies directly.
- Simultaneous duty write and wrap tick: the copy takes the OLD shadow. The new value applies at the next wrap.
- Reset asserted mid-period forces all outputs to reset values immediately (asynchronously).

Decomposition:
- Shared package holds:
  - register addresses (ADDR_DUTY_R..ADDR_STATUS);
  - CTRL bit positions (CTRL_EN = 0, CTRL_BREATHE = 1);
  - breathe state encoding (ST_UP = 0, ST_DOWN = 1).
- Sub-module rgb_pwm_chan, instantiated 3x, holds:
  - shadow and active registers, the copy strobe, the min() with level, the compare and the output register.
  - Ports: clk, rst, wr, din, load, en, breathe, level, ctr, shadow, pwm.
- Prescaler, ctr, breathe FSM and the register decode stay in rgb_pwm_ctrl.

Test Plan:
- Reset check: INVERT = 0, PRESC_RST = 0, assert rst mid-run → pwm_* = 0 immediately; read addr 4 → 0x00; read addr 3 → 0x00.
- Static duty: write DUTY_R = 0x40, DUTY_G = 0x00, DUTY_B = 0xFF, CTRL = 0x01, PRESCALE = 0 → per 256-clk period, pwm_r high 64 clk, pwm_g never high, pwm_b high 255 clk.
- Glitch-free update: mid-period (ctr = 0x80) write DUTY_R 0x40→0xC0 → current period keeps 64 high clk; the next period is 192 high clk.
- Prescaler: PRESCALE = 3, DUTY_G = 0x80 → period 1024 clk, high 512 clk; PRESCALE write mid-period restarts pcnt (next tick 4 clk later).
- Breathe: CTRL = 0x03, DUTY_B = 0xFF, PRESCALE = 0 → LEVEL reads 1 after the first period, 255 after 255 periods with STATUS bit0 = 1, 0 after 510 periods with bit0 = 0. With DUTY_B = 0x20, high time saturates at 32 clk.
- Disable mid-run: clear EN at ctr = 0x50 → next edge pwm_* = INVERT; LEVEL reads 0 and ctr restarts at 0 on re-enable. Repeat the static duty test with INVERT = 1 → outputs are complemented.
